// File: rtl/dark_filter_px.sv
// Streaming dark-mode filter: per-pixel luma, centred KN-tap box mean, hysteretic invert
// decision, sync/DE passed with matched latency, and per-frame inverted-pixel statistics.
module dark_filter_px #(
    parameter int DW = 8,
    parameter int KN = 21,
    parameter int CW = 22
) (
    input  logic            vin_clk_i,
    input  logic            rst_n,
    input  logic            vin_hs_i,
    input  logic            vin_vs_i,
    input  logic            vin_de_i,
    input  logic [3*DW-1:0] vin_data_i,
    input  logic [1:0]      mode_i,
    input  logic [DW-1:0]   thr_i,
    input  logic [DW-1:0]   hyst_i,
    output logic            vout_hs_o,
    output logic            vout_vs_o,
    output logic            vout_de_o,
    output logic [3*DW-1:0] vout_data_o,
    output logic            mask_o,
    output logic [CW-1:0]   frame_inv_cnt_o,
    output logic            frame_done_o
);
    localparam int HW = (KN - 1) / 2;
    localparam int SW = DW + $clog2(KN);
    localparam int PW = 3 * DW;
    localparam int ND = HW + 3;

    // Weights sum to 256, so the shifted result always fits in DW bits.
    function automatic logic [DW-1:0] luma_f(input logic [PW-1:0] px);
        logic [DW+7:0] acc;
        acc = (DW+8)'(px[3*DW-1:2*DW]) * (DW+8)'(9'd77)
            + (DW+8)'(px[2*DW-1:DW])   * (DW+8)'(9'd150)
            + (DW+8)'(px[DW-1:0])      * (DW+8)'(9'd29);
        return DW'(acc >> 8);
    endfunction

    logic [1:0]    mode_q;
    logic [DW-1:0] thr_q, hyst_q;
    logic          vs_in_q;
    logic [SW-1:0] hi_q, lo_q, hi_d, lo_d;
    logic [DW:0]   up_s;
    logic [DW-1:0] y_q, x_s;
    logic [2:0]    ctl_q [ND];
    logic [PW-1:0] dat_q [ND];
    logic [DW-1:0] win_q [KN];
    logic [SW-1:0] s_q;
    logic          ge_hi_q, lt_lo_q, inv_st_q, inv_st_d, inv_base_s;
    logic [2:0]    dctl_s;
    logic [PW-1:0] ddat_s, data_d;
    logic          mask_d, vs_rise_s;
    logic          vout_hs_q, vout_vs_q, vout_de_q, mask_q, fdone_q;
    logic [PW-1:0] vout_data_q;
    logic [CW-1:0] cnt_q, fcnt_q;

    // Config shadow: sampled only on the input-side vsync rising edge
    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vs_in_q <= 1'b0;
            mode_q  <= 2'd0;
            thr_q   <= {1'b1, {(DW-1){1'b0}}};
            hyst_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            vs_in_q <= vin_vs_i;
            if (vin_vs_i && !vs_in_q) begin
                mode_q <= mode_i;
                thr_q  <= thr_i;
                hyst_q <= hyst_i;
            end
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Window-sum thresholds, pre-multiplied by KN so the mean never needs a divide
    always_comb begin
        up_s = {1'b0, thr_q} + {1'b0, hyst_q};
        if (up_s[DW]) hi_d = SW'({DW{1'b1}}) * SW'(KN);
        else          hi_d = SW'(up_s[DW-1:0]) * SW'(KN);
        if (thr_q >= hyst_q) lo_d = SW'(thr_q - hyst_q) * SW'(KN);
        else                 lo_d = '0;
    end

    // Input capture: luma plus the delay line carrying sync/DE/data to the decision stage
    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
            for (int i = 0; i < ND; i++) begin
                ctl_q[i] <= 3'b000;
                dat_q[i] <= '0;
            end
        end else begin
            y_q      <= luma_f(vin_data_i);
            ctl_q[0] <= {vin_hs_i, vin_vs_i, vin_de_i};
            dat_q[0] <= vin_data_i;
            for (int i = 1; i < ND; i++) begin
                ctl_q[i] <= ctl_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // Blanking feeds zeros, so line edges see only their own active pixels
    always_comb begin
        if (ctl_q[0][0]) x_s = y_q;
        else             x_s = '0;
    end

    // Running box sum plus the registered threshold compares
    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KN; i++) win_q[i] <= '0;
            s_q     <= '0;
            ge_hi_q <= 1'b0;
            lt_lo_q <= 1'b0;
        end else begin
            win_q[0] <= x_s;
            for (int i = 1; i < KN; i++) win_q[i] <= win_q[i-1];
            s_q     <= s_q + SW'(x_s) - SW'(win_q[KN-1]);
            ge_hi_q <= (s_q >= hi_q);
            lt_lo_q <= (s_q < lo_q);
        end
    end

    // Hysteretic decision, mode mux and frame-boundary detection
    always_comb begin
        dctl_s = ctl_q[ND-1];
        ddat_s = dat_q[ND-1];
        if (dctl_s[0] && !vout_de_q) inv_base_s = 1'b0;
        else                         inv_base_s = inv_st_q;
        inv_st_d = inv_base_s;
        if (dctl_s[0]) begin
            if (!inv_base_s && ge_hi_q)     inv_st_d = 1'b1;
            else if (inv_base_s && lt_lo_q) inv_st_d = 1'b0;
            else                            inv_st_d = inv_base_s;
        end else begin
            inv_st_d = inv_base_s;
        end
        mask_d = 1'b0;
        case (mode_q)
            2'd1:       mask_d = dctl_s[0];
            2'd2, 2'd3: mask_d = dctl_s[0] & inv_st_d;
            default:    mask_d = 1'b0;
        endcase
        data_d = ddat_s;
        if (!dctl_s[0])          data_d = ddat_s;
        else if (mode_q == 2'd3) data_d = mask_d ? {PW{1'b1}} : {PW{1'b0}};
        else if (mask_d)         data_d = ~ddat_s;
        else                     data_d = ddat_s;
        vs_rise_s = dctl_s[1] & ~vout_vs_q;
    end

    // Output registers and per-frame statistics
    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            inv_st_q    <= 1'b0;
            vout_hs_q   <= 1'b0;
            vout_vs_q   <= 1'b0;
            vout_de_q   <= 1'b0;
            vout_data_q <= '0;
            mask_q      <= 1'b0;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            fdone_q     <= 1'b0;
        end else begin
            inv_st_q    <= inv_st_d;
            vout_hs_q   <= dctl_s[2];
            vout_vs_q   <= dctl_s[1];
            vout_de_q   <= dctl_s[0];
            vout_data_q <= data_d;
            mask_q      <= mask_d;
            if (vs_rise_s) begin
                fcnt_q  <= cnt_q;
                fdone_q <= 1'b1;
                cnt_q   <= {{(CW-1){1'b0}}, mask_d};
            end else begin
                fdone_q <= 1'b0;
                if (mask_d && (cnt_q != {CW{1'b1}})) cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                else                                 cnt_q <= cnt_q;
            end
        end
    end

    assign vout_hs_o       = vout_hs_q;
    assign vout_vs_o       = vout_vs_q;
    assign vout_de_o       = vout_de_q;
    assign vout_data_o     = vout_data_q;
    assign mask_o          = mask_q;
    assign frame_inv_cnt_o = fcnt_q;
    assign frame_done_o    = fdone_q;
endmodule

// File: tb/tb_dark_filter_px.sv
// Bench for dark_filter_px: constant vector table, hand sequences for edges, hysteresis,
// frame-synchronous config and mid-line reset, plus random frames against a windowed reference model.
module tb_dark_filter_px;
    localparam int DW = 8;
    localparam int KN = 21;
    localparam int CW = 22;
    localparam int HW = 10;
    localparam int LAT = 14;
    localparam int MAXN = 60000;
    localparam logic [23:0] BLANK = 24'hA5A5A5;

    logic clk, rst_n, hs_i, vs_i, de_i;
    logic [23:0] data_i;
    logic [1:0] mode_i;
    logic [7:0] thr_i, hyst_i;
    logic hs_o, vs_o, de_o, mask_o, fdone_o;
    logic [23:0] data_o;
    logic [CW-1:0] fcnt_o;

    dark_filter_px #(.DW(DW), .KN(KN), .CW(CW)) dut (
        .vin_clk_i(clk), .rst_n(rst_n), .vin_hs_i(hs_i), .vin_vs_i(vs_i), .vin_de_i(de_i),
        .vin_data_i(data_i), .mode_i(mode_i), .thr_i(thr_i), .hyst_i(hyst_i),
        .vout_hs_o(hs_o), .vout_vs_o(vs_o), .vout_de_o(de_o), .vout_data_o(data_o),
        .mask_o(mask_o), .frame_inv_cnt_o(fcnt_o), .frame_done_o(fdone_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        int          thr;
        int          hyst;
        logic [23:0] px;
        logic [23:0] exp_px;
        bit          exp_mask;
    } vec_t;

    // Input history since the last reset, with the frame config each pixel belongs to
    logic [23:0] h_data [MAXN];
    bit          h_hs [MAXN], h_vs [MAXN], h_de [MAXN];
    int          h_mode [MAXN], h_thr [MAXN], h_hyst [MAXN];
    int n;
    int sh_mode, sh_thr, sh_hyst;
    bit in_vs_prev, m_inv, m_de_prev, m_vs_prev;
    int m_cnt, m_frame_cnt;
    int checks, errors;
    int probe_m;
    logic [23:0] probe_data;
    bit probe_mask;
    bit act_de_prev, act_mask_prev;
    int act_px, act_cnt, act_first, act_last, act_rises, done_cnt;
    logic [CW-1:0] last_done_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int yof(input int i);
        if (i < 0 || i >= n || !h_de[i]) return 0;
        return (77 * int'(h_data[i][23:16]) + 150 * int'(h_data[i][15:8]) + 29 * int'(h_data[i][7:0])) / 256;
    endfunction

    task automatic model_reset();
        n = 0; sh_mode = 0; sh_thr = 128; sh_hyst = 0; in_vs_prev = 1'b0;
        m_inv = 1'b0; m_de_prev = 1'b0; m_vs_prev = 1'b0; m_cnt = 0; m_frame_cnt = 0;
        act_de_prev = 1'b0; act_mask_prev = 1'b0; probe_m = -1;
    endtask

    task automatic check_out(input int m);
        bit e_de, e_hs, e_vs, e_mask, e_done;
        logic [23:0] e_data;
        int s, hi, lo, md, t, hy;
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_data = 24'h0; md = 0; t = 128; hy = 0;
        if (m >= 0) begin
            e_de = h_de[m]; e_hs = h_hs[m]; e_vs = h_vs[m]; e_data = h_data[m];
            md = h_mode[m]; t = h_thr[m]; hy = h_hyst[m];
        end
        s = 0;
        for (int k = -HW; k <= HW; k++) s += yof(m + k);
        hi = ((t + hy > 255) ? 255 : t + hy) * KN;
        lo = ((t - hy < 0) ? 0 : t - hy) * KN;
        if (e_de && !m_de_prev) m_inv = 1'b0;
        if (e_de) begin
            if (!m_inv && s >= hi) m_inv = 1'b1;
            else if (m_inv && s < lo) m_inv = 1'b0;
        end
        m_de_prev = e_de;
        e_mask = e_de && (md == 1 || (md >= 2 && m_inv));
        if (e_de && md == 3) e_data = e_mask ? 24'hFFFFFF : 24'h000000;
        else if (e_mask) e_data = ~e_data;
        if (e_vs && !m_vs_prev) begin
            e_done = 1'b1; m_frame_cnt = m_cnt; m_cnt = int'(e_mask);
        end else begin
            e_done = 1'b0;
            if (e_mask && m_cnt < (2 ** CW) - 1) m_cnt++;
        end
        m_vs_prev = e_vs;
        chk("vout_hs", hs_o, e_hs);
        chk("vout_vs", vs_o, e_vs);
        chk("vout_de", de_o, e_de);
        chk("vout_data", data_o, e_data);
        chk("mask", mask_o, e_mask);
        chk("frame_done", fdone_o, e_done);
        chk("frame_inv_cnt", fcnt_o, m_frame_cnt);
        if (m >= 0 && m == probe_m) begin
            chk("table_data", data_o, probe_data);
            chk("table_mask", mask_o, probe_mask);
            probe_m = -1;
        end
        if (de_o) begin
            if (!act_de_prev) act_px = 0;
            else act_px++;
        end
        if (mask_o) begin
            act_cnt++;
            if (act_first < 0) act_first = act_px;
            act_last = act_px;
        end
        if (mask_o && !act_mask_prev) act_rises++;
        if (fdone_o) begin done_cnt++; last_done_val = fcnt_o; end
        act_de_prev = de_o; act_mask_prev = mask_o;
    endtask

    task automatic step(input bit hs, input bit vs, input bit de, input logic [23:0] px);
        if (n >= MAXN) begin
            $display("FAIL history_overflow: got %0d expected below %0d", n, MAXN);
            $fatal(1, "history overflow");
        end
        hs_i = hs; vs_i = vs; de_i = de; data_i = px;
        if (vs && !in_vs_prev) begin
            sh_mode = int'(mode_i); sh_thr = int'(thr_i); sh_hyst = int'(hyst_i);
        end
        in_vs_prev = vs;
        h_hs[n] = hs; h_vs[n] = vs; h_de[n] = de; h_data[n] = px;
        h_mode[n] = sh_mode; h_thr[n] = sh_thr; h_hyst[n] = sh_hyst;
        n++;
        @(posedge clk);
        #1;
        check_out(n - LAT);
    endtask

    task automatic vs_pulse();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, BLANK);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, BLANK);
    endtask

    task automatic line_const(input int npx, input logic [23:0] px, input int nblank);
        for (int i = 0; i < npx; i++) step(1'b0, 1'b0, 1'b1, px);
        for (int i = 0; i < nblank; i++) step(i < 4, 1'b0, 1'b0, BLANK);
    endtask

    task automatic clear_act();
        act_cnt = 0; act_first = -1; act_last = -1; act_rises = 0;
    endtask

    vec_t tbl [14];
    logic [23:0] px;
    logic [7:0] g;
    int npx, nbl;

    initial begin
        tbl[0]  = '{2'd0, 128, 0,   24'h123456, 24'h123456, 1'b0};
        tbl[1]  = '{2'd1, 128, 0,   24'hFFFFFF, 24'h000000, 1'b1};
        tbl[2]  = '{2'd2, 128, 0,   24'hC8C8C8, 24'h373737, 1'b1};
        tbl[3]  = '{2'd2, 128, 0,   24'h404040, 24'h404040, 1'b0};
        tbl[4]  = '{2'd3, 128, 0,   24'hC8C8C8, 24'hFFFFFF, 1'b1};
        tbl[5]  = '{2'd3, 128, 0,   24'h404040, 24'h000000, 1'b0};
        tbl[6]  = '{2'd2, 200, 0,   24'hC8C8C8, 24'h373737, 1'b1};
        tbl[7]  = '{2'd2, 201, 0,   24'hC8C8C8, 24'hC8C8C8, 1'b0};
        tbl[8]  = '{2'd2, 0,   0,   24'h000000, 24'hFFFFFF, 1'b1};
        tbl[9]  = '{2'd2, 255, 10,  24'hFFFFFF, 24'h000000, 1'b1};
        tbl[10] = '{2'd2, 76,  0,   24'hFF0000, 24'h00FFFF, 1'b1};
        tbl[11] = '{2'd2, 77,  0,   24'hFF0000, 24'hFF0000, 1'b0};
        tbl[12] = '{2'd2, 140, 20,  24'hC8C8C8, 24'h373737, 1'b1};
        tbl[13] = '{2'd3, 100, 120, 24'h404040, 24'h000000, 1'b0};
        checks = 0; errors = 0; done_cnt = 0; last_done_val = '0; act_px = 0;
        clear_act();
        rst_n = 1'b0; hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b0; data_i = 24'h0;
        mode_i = 2'd0; thr_i = 8'd128; hyst_i = 8'd0;
        model_reset();
        #3;
        chk("reset_hs", hs_o, 1'b0); chk("reset_vs", vs_o, 1'b0); chk("reset_de", de_o, 1'b0);
        chk("reset_data", data_o, 24'h0); chk("reset_mask", mask_o, 1'b0);
        chk("reset_cnt", fcnt_o, 22'h0); chk("reset_done", fdone_o, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Bypass with random sync and isolated active pixels
        vs_pulse();
        for (int i = 0; i < 80; i++) begin
            if (i == 30) begin probe_m = n; probe_data = 24'h123456; probe_mask = 1'b0; end
            if (i % 20 == 10) step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1, 24'h123456);
            else step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0, 24'($urandom));
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, BLANK);

        // Constant-line vector table, probed at the line centre
        foreach (tbl[i]) begin
            mode_i = tbl[i].mode; thr_i = 8'(tbl[i].thr); hyst_i = 8'(tbl[i].hyst);
            vs_pulse();
            probe_m = n + 20; probe_data = tbl[i].exp_px; probe_mask = tbl[i].exp_mask;
            line_const(40, tbl[i].px, 30);
        end

        // Adaptive line edges
        mode_i = 2'd2; thr_i = 8'd128; hyst_i = 8'd0;
        vs_pulse();
        clear_act();
        line_const(100, 24'hC8C8C8, 200);
        chk("edge_count", act_cnt, 94); chk("edge_first", act_first, 3); chk("edge_last", act_last, 96);

        // Hysteresis ramp: a single set and a single clear
        hyst_i = 8'd32;
        vs_pulse();
        clear_act();
        for (int v = 0; v <= 255; v += 5) step(1'b0, 1'b0, 1'b1, {3{8'(v)}});
        for (int v = 250; v >= 0; v -= 5) step(1'b0, 1'b0, 1'b1, {3{8'(v)}});
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, BLANK);
        chk("hyst_rises", act_rises, 1);

        // Frame-synchronous config: mode change mid-frame waits for the next vsync
        mode_i = 2'd0; hyst_i = 8'd0;
        vs_pulse();
        clear_act();
        line_const(100, 24'hC8C8C8, 200);
        mode_i = 2'd2;
        line_const(100, 24'hC8C8C8, 200);
        line_const(100, 24'hC8C8C8, 200);
        chk("sync_old_frame_mask", act_cnt, 0);
        done_cnt = 0;
        vs_pulse();
        chk("sync_done_b", done_cnt, 1); chk("sync_cnt_a", last_done_val, 22'd0);
        for (int l = 0; l < 3; l++) line_const(100, 24'hC8C8C8, 200);
        vs_pulse();
        chk("sync_done_c", done_cnt, 2); chk("sync_cnt_b", last_done_val, 22'd282);

        // Random frames, with ignored mid-frame config changes
        for (int f = 0; f < 5; f++) begin
            mode_i = 2'($urandom_range(3, 0)); thr_i = 8'($urandom); hyst_i = 8'($urandom_range(60, 0));
            vs_pulse();
            for (int l = 0; l < 3; l++) begin
                npx = int'($urandom_range(80, 20));
                g = 8'($urandom);
                for (int i = 0; i < npx; i++) begin
                    g = g + 8'($urandom_range(16, 0)) - 8'd8;
                    if ($urandom_range(3, 0) == 0) px = 24'($urandom);
                    else px = {g, g, g};
                    step(1'b0, 1'b0, 1'b1, px);
                end
                if (l == 1) begin
                    mode_i = 2'($urandom); thr_i = 8'($urandom); hyst_i = 8'($urandom);
                end
                nbl = int'($urandom_range(40, 25));
                for (int i = 0; i < nbl; i++) step(i < 3, 1'b0, 1'b0, 24'($urandom));
            end
        end

        // Asynchronous reset in the middle of an active line
        mode_i = 2'd2; thr_i = 8'd128; hyst_i = 8'd0;
        vs_pulse();
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, 24'hC8C8C8);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hs", hs_o, 1'b0); chk("rst_vs", vs_o, 1'b0); chk("rst_de", de_o, 1'b0);
        chk("rst_data", data_o, 24'h0); chk("rst_mask", mask_o, 1'b0);
        chk("rst_cnt", fcnt_o, 22'h0); chk("rst_done", fdone_o, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            if (i == 5) begin probe_m = n; probe_data = 24'h123456; probe_mask = 1'b0; end
            step(1'b0, 1'b0, 1'b1, (i == 5) ? 24'h123456 : 24'($urandom));
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, BLANK);
        vs_pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
